// File: rtl/rc4_key_search_ctrl.sv
// Key-search sequencer for the RC4 brute-force decryptor; also muxes the shared S RAM.
// Define RC4_PHASE_TIMEOUT_EN to build the per-phase watchdog that drives timeout_err.
module rc4_key_search_ctrl #(
   parameter int                KEY_W          = 24,
   parameter logic [KEY_W-1:0]  KEY_MAX        = 24'h3FFFFF,
   parameter int                ADDR_W         = 8,
   parameter int                DATA_W         = 8,
   parameter int                TIMEOUT_CYCLES = 4096
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [KEY_W-1:0]  key_base,
   output logic              sub_reset_n,
   output logic              init_start,
   output logic              ksa_start,
   output logic              prga_start,
   input  logic              init_done,
   input  logic              ksa_done,
   input  logic              prga_done,
   input  logic              prga_fail,
   input  logic [ADDR_W-1:0] init_addr,
   input  logic [ADDR_W-1:0] ksa_addr,
   input  logic [ADDR_W-1:0] prga_addr,
   input  logic [DATA_W-1:0] init_data,
   input  logic [DATA_W-1:0] ksa_data,
   input  logic [DATA_W-1:0] prga_data,
   input  logic              init_wren,
   input  logic              ksa_wren,
   input  logic              prga_wren,
   output logic [ADDR_W-1:0] s_address,
   output logic [DATA_W-1:0] s_data,
   output logic              s_wren,
   output logic [KEY_W-1:0]  sec_key,
   output logic              busy,
   output logic              found,
   output logic              exhausted,
   output logic              timeout_err,
   output logic [2:0]        state_dbg
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLEAR   = 3'd1,
      INIT    = 3'd2,
      KSA     = 3'd3,
      PRGA    = 3'd4,
      NEXT    = 3'd5,
      FOUND   = 3'd6,
      EXHAUST = 3'd7
   } state_t;

   state_t state;
   logic   idle_like;
   logic   phase_expired;

   assign state_dbg = state;
   assign idle_like = (state == IDLE) || (state == FOUND) || (state == EXHAUST);

`ifdef RC4_PHASE_TIMEOUT_EN
   logic [12:0] phase_cnt;
   logic        in_phase;
   logic        phase_hit;

   assign in_phase  = (state == INIT) || (state == KSA) || (state == PRGA);
   assign phase_hit = ((state == INIT) && init_done) ||
                      ((state == KSA)  && ksa_done)  ||
                      ((state == PRGA) && (prga_done || prga_fail));
   // Counter is 0 on the first cycle of each phase, so a phase lasts at most TIMEOUT_CYCLES cycles.
   assign phase_expired = in_phase && !phase_hit && (phase_cnt == 13'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase_cnt   <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (!in_phase || phase_hit) phase_cnt <= '0;
         else                        phase_cnt <= phase_cnt + 13'd1;
         if (idle_like && start)               timeout_err <= 1'b0;
         else if (phase_expired && !abort)     timeout_err <= 1'b1;
      end
   end
`else
   assign phase_expired = 1'b0;
   assign timeout_err   = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         sec_key     <= '0;
         sub_reset_n <= 1'b0;
         init_start  <= 1'b0;
         ksa_start   <= 1'b0;
         prga_start  <= 1'b0;
         busy        <= 1'b0;
         found       <= 1'b0;
         exhausted   <= 1'b0;
      end else begin
         case (state)
            IDLE, FOUND, EXHAUST: begin
               if (start) begin
                  sec_key     <= key_base;
                  found       <= 1'b0;
                  exhausted   <= 1'b0;
                  busy        <= 1'b1;
                  sub_reset_n <= 1'b0;
                  state       <= CLEAR;
               end
            end
            default: begin
               if (abort) begin
                  init_start  <= 1'b0;
                  ksa_start   <= 1'b0;
                  prga_start  <= 1'b0;
                  sub_reset_n <= 1'b0;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end else begin
                  case (state)
                     CLEAR: begin
                        sub_reset_n <= 1'b1;
                        init_start  <= 1'b1;
                        state       <= INIT;
                     end
                     INIT: begin
                        if (init_done) begin
                           init_start <= 1'b0;
                           ksa_start  <= 1'b1;
                           state      <= KSA;
                        end else if (phase_expired) begin
                           init_start <= 1'b0;
                           state      <= NEXT;
                        end
                     end
                     KSA: begin
                        if (ksa_done) begin
                           ksa_start  <= 1'b0;
                           prga_start <= 1'b1;
                           state      <= PRGA;
                        end else if (phase_expired) begin
                           ksa_start <= 1'b0;
                           state     <= NEXT;
                        end
                     end
                     PRGA: begin
                        // A fail reported together with done still rejects the key.
                        if (prga_fail || phase_expired) begin
                           prga_start <= 1'b0;
                           state      <= NEXT;
                        end else if (prga_done) begin
                           prga_start  <= 1'b0;
                           found       <= 1'b1;
                           busy        <= 1'b0;
                           sub_reset_n <= 1'b0;
                           state       <= FOUND;
                        end
                     end
                     NEXT: begin
                        sub_reset_n <= 1'b0;
                        if (sec_key == KEY_MAX) begin
                           exhausted <= 1'b1;
                           busy      <= 1'b0;
                           state     <= EXHAUST;
                        end else begin
                           sec_key <= sec_key + 1'b1;
                           state   <= CLEAR;
                        end
                     end
                     default: state <= IDLE;
                  endcase
               end
            end
         endcase
      end
   end

   always_comb begin
      s_address = '0;
      s_data    = '0;
      s_wren    = 1'b0;
      case (state)
         INIT: begin
            s_address = init_addr;
            s_data    = init_data;
            s_wren    = init_wren;
         end
         KSA: begin
            s_address = ksa_addr;
            s_data    = ksa_data;
            s_wren    = ksa_wren;
         end
         PRGA: begin
            s_address = prga_addr;
            s_data    = prga_data;
            s_wren    = prga_wren;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Directed bench for rc4_key_search_ctrl: engine handshakes, key stepping, RAM mux, abort, reset.
module tb_rc4_key_search_ctrl;

   localparam logic [2:0] S_IDLE = 3'd0, S_CLEAR = 3'd1, S_INIT = 3'd2, S_KSA = 3'd3,
                          S_PRGA = 3'd4, S_NEXT = 3'd5, S_FOUND = 3'd6, S_EXHAUST = 3'd7;
   localparam logic [23:0] KMAX = 24'h3FFFFF;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0, abort = 1'b0;
   logic [23:0] key_base = '0;
   logic        sub_reset_n, init_start, ksa_start, prga_start;
   logic        init_done = 1'b0, ksa_done = 1'b0, prga_done = 1'b0, prga_fail = 1'b0;
   // Engines present fixed, distinct bus values so the mux selection is visible.
   logic [7:0]  init_addr = 8'h11, ksa_addr = 8'h3C, prga_addr = 8'h77;
   logic [7:0]  init_data = 8'h22, ksa_data = 8'hA5, prga_data = 8'h88;
   logic        init_wren = 1'b1, ksa_wren = 1'b0, prga_wren = 1'b1;
   logic [7:0]  s_address, s_data;
   logic        s_wren;
   logic [23:0] sec_key;
   logic        busy, found, exhausted, timeout_err;
   logic [2:0]  state_dbg;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   rc4_key_search_ctrl #(.TIMEOUT_CYCLES(100)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .key_base(key_base),
      .sub_reset_n(sub_reset_n), .init_start(init_start), .ksa_start(ksa_start),
      .prga_start(prga_start), .init_done(init_done), .ksa_done(ksa_done),
      .prga_done(prga_done), .prga_fail(prga_fail),
      .init_addr(init_addr), .ksa_addr(ksa_addr), .prga_addr(prga_addr),
      .init_data(init_data), .ksa_data(ksa_data), .prga_data(prga_data),
      .init_wren(init_wren), .ksa_wren(ksa_wren), .prga_wren(prga_wren),
      .s_address(s_address), .s_data(s_data), .s_wren(s_wren),
      .sec_key(sec_key), .busy(busy), .found(found), .exhausted(exhausted),
      .timeout_err(timeout_err), .state_dbg(state_dbg)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ram(input string tag, input logic [2:0] st);
      logic [7:0] ea, ed;
      logic       ew;
      ea = 8'h00; ed = 8'h00; ew = 1'b0;
      if (st == S_INIT) begin ea = 8'h11; ed = 8'h22; ew = 1'b1; end
      if (st == S_KSA)  begin ea = 8'h3C; ed = 8'hA5; ew = 1'b0; end
      if (st == S_PRGA) begin ea = 8'h77; ed = 8'h88; ew = 1'b1; end
      chk({tag, "_addr"}, s_address, ea);
      chk({tag, "_data"}, s_data, ed);
      chk({tag, "_wren"}, s_wren, ew);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_state"}, state_dbg, S_IDLE);
      chk({tag, "_key"}, sec_key, 0);
      chk({tag, "_rstn"}, sub_reset_n, 0);
      chk({tag, "_starts"}, {init_start, ksa_start, prga_start}, 0);
      chk({tag, "_flags"}, {busy, found, exhausted, timeout_err}, 0);
      chk_ram(tag, S_IDLE);
   endtask

   // Pulse start and land on the first INIT cycle.
   task automatic begin_search(input logic [23:0] k);
      key_base = k;
      start = 1'b1;
      tick;
      start = 1'b0;
      chk("clear_state", state_dbg, S_CLEAR);
      chk("clear_key", sec_key, {8'h0, k});
      chk("clear_rstn", sub_reset_n, 0);
      chk("clear_flags", {busy, found, exhausted}, 3'b100);
      chk_ram("ram_clear", S_CLEAR);
      tick;
   endtask

   // One key attempt starting on the first INIT cycle; outcome 0=fail, 1=pass, 2=done+fail.
   task automatic attempt(input logic [23:0] k, input int lat, input int outcome);
      chk("init_state", state_dbg, S_INIT);
      chk("init_key", sec_key, {8'h0, k});
      chk("init_rstn", sub_reset_n, 1);
      chk("init_starts", {init_start, ksa_start, prga_start}, 3'b100);
      chk("init_busy", busy, 1);
      chk_ram("ram_init", S_INIT);
      ksa_done = 1'b1; prga_done = 1'b1;
      repeat (lat) tick;
      chk("init_stray_ignored", state_dbg, S_INIT);
      ksa_done = 1'b0; prga_done = 1'b0; init_done = 1'b1;
      tick;
      init_done = 1'b0;
      chk("ksa_state", state_dbg, S_KSA);
      chk("ksa_starts", {init_start, ksa_start, prga_start}, 3'b010);
      chk_ram("ram_ksa", S_KSA);
      init_done = 1'b1; prga_done = 1'b1;
      repeat (lat) tick;
      chk("ksa_stray_ignored", state_dbg, S_KSA);
      init_done = 1'b0; prga_done = 1'b0; ksa_done = 1'b1;
      tick;
      ksa_done = 1'b0;
      chk("prga_state", state_dbg, S_PRGA);
      chk("prga_starts", {init_start, ksa_start, prga_start}, 3'b001);
      chk_ram("ram_prga", S_PRGA);
      repeat (lat) tick;
      prga_fail = (outcome != 1);
      prga_done = (outcome != 0);
      tick;
      prga_fail = 1'b0; prga_done = 1'b0;
      chk("post_starts", {init_start, ksa_start, prga_start}, 0);
      chk("post_key", sec_key, {8'h0, k});
      if (outcome == 1) begin
         chk("found_state", state_dbg, S_FOUND);
         chk("found_flags", {busy, found, exhausted}, 3'b010);
      end else begin
         chk("next_state", state_dbg, S_NEXT);
         chk("next_rstn", sub_reset_n, 1);
         chk_ram("ram_next", S_NEXT);
         tick;
         if (k == KMAX) begin
            chk("exh_state", state_dbg, S_EXHAUST);
            chk("exh_flags", {busy, found, exhausted}, 3'b001);
            chk("exh_key", sec_key, {8'h0, KMAX});
         end else begin
            chk("reclear_state", state_dbg, S_CLEAR);
            chk("reclear_rstn", sub_reset_n, 0);
            chk("reclear_key", sec_key, {8'h0, k + 24'd1});
            chk("reclear_busy", busy, 1);
            tick;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state while reset is held, then after release.
      #1;
      chk_reset_vals("rst_hold");
      tick; tick;
      reset = 1'b0;
      tick;
      chk_reset_vals("rst_release");

      // Pass on the third key: 0x10, 0x11 fail, 0x12 passes.
      begin_search(24'h000010);
      attempt(24'h000010, 2, 0);
      attempt(24'h000011, 0, 0);
      attempt(24'h000012, 3, 1);
      tick; tick; tick;
      chk("found_hold_state", state_dbg, S_FOUND);
      chk("found_hold_key", sec_key, 32'h12);
      chk("found_hold_flags", {busy, found}, 2'b01);
      chk("found_rstn", sub_reset_n, 0);

      // Restart from FOUND; done+fail together at key 7 rejects it, search moves to 8.
      begin_search(24'h000007);
      attempt(24'h000007, 1, 2);
      key_base = 24'h000030;
      start = 1'b1;
      tick;
      start = 1'b0;
      chk("start_busy_ignored_key", sec_key, 32'h8);
      chk("start_busy_ignored_state", state_dbg, S_INIT);
      init_done = 1'b1;
      tick;
      init_done = 1'b0;
      chk("abort_pre_state", state_dbg, S_KSA);
      abort = 1'b1; ksa_done = 1'b1;
      tick;
      abort = 1'b0; ksa_done = 1'b0;
      chk("abort_state", state_dbg, S_IDLE);
      chk("abort_starts", {init_start, ksa_start, prga_start}, 0);
      chk("abort_flags", {busy, found, exhausted}, 0);
      chk("abort_rstn", sub_reset_n, 0);
      chk_ram("ram_abort", S_IDLE);

      // Last three keys of the keyspace all fail.
      begin_search(24'h3FFFFD);
      attempt(24'h3FFFFD, 0, 0);
      attempt(24'h3FFFFE, 1, 0);
      attempt(24'h3FFFFF, 0, 0);
      tick; tick;
      chk("exh_hold_state", state_dbg, S_EXHAUST);
      chk("exh_hold_key", sec_key, {8'h0, KMAX});
      chk("exh_hold_flags", {busy, found, exhausted}, 3'b001);

      // KSA that never completes.
      begin_search(24'h000040);
      init_done = 1'b1;
      tick;
      init_done = 1'b0;
      chk("hang_ksa_state", state_dbg, S_KSA);
`ifdef RC4_PHASE_TIMEOUT_EN
      repeat (99) tick;
      chk("tmo_last_ksa_state", state_dbg, S_KSA);
      chk("tmo_not_yet", timeout_err, 0);
      tick;
      chk("tmo_next_state", state_dbg, S_NEXT);
      chk("tmo_flag", timeout_err, 1);
      tick;
      chk("tmo_clear_state", state_dbg, S_CLEAR);
      chk("tmo_next_key", sec_key, 32'h41);
      abort = 1'b1;
      tick;
      abort = 1'b0;
      chk("tmo_sticky", timeout_err, 1);
`else
      repeat (150) tick;
      chk("hang_still_ksa", state_dbg, S_KSA);
      chk("hang_ksa_start", ksa_start, 1);
      chk("hang_no_tmo", timeout_err, 0);
      chk("hang_key", sec_key, 32'h40);
      abort = 1'b1;
      tick;
      abort = 1'b0;
`endif
      chk("hang_abort_state", state_dbg, S_IDLE);

      // Asynchronous reset in the middle of PRGA at key 5.
      begin_search(24'h000005);
      init_done = 1'b1;
      tick;
      init_done = 1'b0; ksa_done = 1'b1;
      tick;
      ksa_done = 1'b0;
      chk("mid_prga_state", state_dbg, S_PRGA);
      chk("mid_prga_key", sec_key, 32'h5);
      #2;
      reset = 1'b1;
      #1;
      chk_reset_vals("async_rst");
      tick;
      reset = 1'b0;
      tick;
      chk("after_rst_state", state_dbg, S_IDLE);
      chk("after_rst_busy", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rc4_key_search_ctrl.md
Name: rc4_key_search_ctrl

Overview:
- Top-level sequencer for the RC4 brute-force decryptor.
- For each candidate key it resets the S-memory phase engines and runs them in order: init (S[i]=i), KSA swap loop, then PRGA/decrypt-and-check. It advances the key until a pass or until the keyspace is exhausted.
- It also arbitrates the single-port 256x8 S RAM between the three engines: only the active phase reaches the RAM.

Parameters:
- KEY_W, 24, secret key width; drives sec_key to the KSA engine.
- KEY_MAX, 24'h3FFFFF, last key tried; upper key bits are fixed zero.
- ADDR_W, 8, S RAM address width.
- DATA_W, 8, S RAM data width.
- TIMEOUT_CYCLES, 4096, per-phase watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begin search at key_base
- abort  in  1  level; stop search and return to IDLE
- key_base  in  KEY_W  first key to try
- sub_reset_n  out  1  active-low reset to the init, KSA and PRGA engines
- init_start, ksa_start, prga_start  out  1 each  level start flags to the engines
- init_done, ksa_done, prga_done  in  1 each  engine done flags
- prga_fail  in  1  PRGA found a non-printable plaintext byte (early reject)
- init_addr, ksa_addr, prga_addr  in  ADDR_W each  engine RAM addresses
- init_data, ksa_data, prga_data  in  DATA_W each  engine RAM write data
- init_wren, ksa_wren, prga_wren  in  1 each  engine write enables
- s_address  out  ADDR_W  to S RAM
- s_data  out  DATA_W  to S RAM
- s_wren  out  1  to S RAM
- sec_key  out  KEY_W  current candidate key
- busy  out  1  search in progress
- found  out  1  sticky; key located
- exhausted  out  1  sticky; KEY_MAX tried without a pass
- timeout_err  out  1  sticky; present only with the optional feature, otherwise tied 0

Behaviour:
- Reset (reset=1, asynchronous):
  - state=IDLE; sec_key=0; sub_reset_n=0.
  - All *_start=0; s_address=0, s_data=0, s_wren=0.
  - busy=0, found=0, exhausted=0, timeout_err=0.
- States: IDLE, CLEAR, INIT, KSA, PRGA, NEXT, FOUND, EXHAUST.
- IDLE:
  - sub_reset_n=0; outputs idle.
  - start=1 → sec_key<=key_base; clear found, exhausted, timeout_err; busy<=1; go to CLEAR.
- CLEAR: exactly 1 cycle with sub_reset_n=0, then sub_reset_n<=1 and go to INIT.
- INIT: init_start=1 until init_done=1 is sampled, then init_start<=0 and go to KSA.
- KSA: ksa_start=1 until ksa_done=1, then go to PRGA.
- PRGA: prga_start=1.
  - prga_fail=1 → NEXT.
  - prga_done=1 with prga_fail=0 → FOUND.
  - prga_done and prga_fail in the same cycle → fail wins, go to NEXT.
- NEXT:
  - sec_key==KEY_MAX → EXHAUST.
  - Otherwise sec_key<=sec_key+1 and go to CLEAR. No wrap past KEY_MAX.
  - Per-key overhead is 2 cycles (NEXT + CLEAR) plus the engine latencies.
- FOUND: found=1, busy=0, sec_key held; stays until start or reset.
- EXHAUST: exhausted=1, busy=0; stays until start or reset.
- Starting from a terminal state: start=1 behaves exactly as in IDLE.
- start while busy: ignored.
- abort=1 in any busy state:
  - Next cycle go to IDLE; all starts=0; sub_reset_n=0; busy=0.
  - found and exhausted are not set.
  - abort has priority over done/fail in the same cycle.
- RAM arbitration (combinational mux, registered select = state):
  - INIT passes init_* to s_address/s_data/s_wren.
  - KSA passes ksa_*.
  - PRGA passes prga_*.
  - All other states: s_wren=0, s_address=0, s_data=0.
  - A non-selected engine's wren never reaches the RAM.
- Done flags are level; only the flag of the active phase is sampled. Stray done flags from other engines are ignored.

Optional Feature:
- Macro: RC4_PHASE_TIMEOUT_EN.
- Enabled:
  - A 13-bit phase cycle counter clears on entry to INIT, KSA and PRGA.
  - If it reaches TIMEOUT_CYCLES before that phase's done, set timeout_err (sticky) and treat the attempt as failed (go to NEXT).
- Disabled: no counter is built; timeout_err is driven constant 0; phases wait indefinitely.

Test Plan:
- Reset mid-PRGA (key=5) → all outputs at reset values within 0 cycles of reset rising; state IDLE after release.
- key_base=0, KEY_MAX=2 (override), engine models fail every key → sec_key sequence 0,1,2; exhausted=1, busy=0, found=0; no increment past 2.
- key_base=0x000010, model passes only at 0x000012 → found=1, sec_key=0x000012 held; sub_reset_n low exactly 1 cycle before each of 3 attempts.
- prga_done=1 and prga_fail=1 together at key 7 → treated as fail; next attempt uses key 8.
- During KSA, drive init_wren=1 and prga_wren=1 with ksa_wren=0 → s_wren=0; ksa_addr=0x3C appears on s_address.
- With RC4_PHASE_TIMEOUT_EN and TIMEOUT_CYCLES=100, ksa_done never asserted → after 100 cycles timeout_err=1 and sec_key increments; with the macro undefined, the controller stays in KSA.
